ifft8_unit: RTL and testbench

// - 8-point radix-2 DIT inverse FFT coprocessor; inverse direction of the ALU's word-serial FFT path.
// - Accepts 16 word-serial frequency samples (X0.re, X0.im ... X7.re, X7.im) and computes x[n] = (1/8)*sum X[k]*W^-nk.
// - Returns 16 word-serial time samples in natural order.
// - Sits beside alu; the ALU load/export opcodes feed din and drain dout through valid/ready handshakes.

---
 rtl/ifft8_unit_pkg.sv | 75 +++++++
 rtl/ifft8_unit_if.sv | 18 +
 rtl/ifft_bf2.sv | 38 +++
 rtl/ifft8_unit.sv | 106 ++++++++++
 tb/tb_ifft8_unit.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifft8_unit_pkg.sv
// Shared types and constants for the 8-point inverse FFT coprocessor.
// - State encoding, word/twiddle widths, conjugate twiddle table.
// - Butterfly lane -> data slot mapping for each of the three DIT stages.
package ifft8_unit_pkg;
  localparam int DW      = 32;
  localparam int TW_W    = 16;
  localparam int TW_FRAC = 14;
  localparam int NPTS    = 8;
  localparam int NUM_BF  = 4;

  localparam logic signed [TW_W-1:0] COS45 = 16'sd11585;
  localparam logic signed [TW_W-1:0] ONE   = 16'sd16384;

  typedef enum logic [2:0] {S_LOAD, S_ST1, S_ST2, S_ST3, S_EXPORT} state_t;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [TW_W-1:0] re;
    logic signed [TW_W-1:0] im;
  } tw_t;

  function automatic logic [2:0] rev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  // W^-k for k = 0..3 (conjugate direction of the forward FFT).
  function automatic tw_t tw_conj(input logic [1:0] k);
    tw_t t;
    case (k)
      2'd0:    begin t.re = ONE;    t.im = '0;    end
      2'd1:    begin t.re = COS45;  t.im = COS45; end
      2'd2:    begin t.re = '0;     t.im = ONE;   end
      default: begin t.re = -COS45; t.im = COS45; end
    endcase
    return t;
  endfunction

  // Upper operand slot of lane i: span 1, span 2, span 4 pairings.
  function automatic logic [2:0] bf_a_idx(input state_t st, input logic [1:0] i);
    case (st)
      S_ST1:   return {i, 1'b0};
      S_ST2:   return {i[1], 1'b0, i[0]};
      default: return {1'b0, i};
    endcase
  endfunction

  function automatic logic [2:0] bf_b_idx(input state_t st, input logic [1:0] i);
    case (st)
      S_ST1:   return {i, 1'b1};
      S_ST2:   return {i[1], 1'b1, i[0]};
      default: return {1'b1, i};
    endcase
  endfunction

  // Twiddle exponent: ST1 always 0, ST2 0 or 2 (the +j rotation), ST3 lane index.
  function automatic logic [1:0] bf_tw_idx(input state_t st, input logic [1:0] i);
    case (st)
      S_ST1:   return 2'd0;
      S_ST2:   return {i[0], 1'b0};
      default: return i;
    endcase
  endfunction

  // Final 1/8 scaling, floor via arithmetic shift.
  function automatic cplx_t scale8(input cplx_t c);
    cplx_t r;
    r.re = $signed(c.re) >>> 3;
    r.im = $signed(c.im) >>> 3;
    return r;
  endfunction
endpackage

// File: rtl/ifft8_unit_if.sv
// Word-serial load/export handshake bundle between the ALU and ifft8_unit.
// - din_valid/din_ready/din : frequency samples into the unit
// - dout_valid/dout_ready/dout/dout_last : time samples out of the unit
interface ifft8_unit_if;
  import ifft8_unit_pkg::*;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] din;
  logic          dout_valid;
  logic          dout_ready;
  logic [DW-1:0] dout;
  logic          dout_last;

  modport master (output din_valid, din, dout_ready,
                  input  din_ready, dout_valid, dout, dout_last);
  modport slave  (input  din_valid, din, dout_ready,
                  output din_ready, dout_valid, dout, dout_last);
endinterface

// File: rtl/ifft_bf2.sv
// Combinational radix-2 complex butterfly: ap = a + b*w, bp = a - b*w.
// - a, b : complex DW-bit operands
// - w    : complex twiddle, TW_FRAC fraction bits
// Product sums are kept at DW+TW_W+1 bits, floored by TW_FRAC, truncated to DW.
module ifft_bf2
  import ifft8_unit_pkg::*;
(
  input  cplx_t a,
  input  cplx_t b,
  input  tw_t   w,
  output cplx_t ap,
  output cplx_t bp
);
  localparam int PW = DW + TW_W + 1;

  logic signed [PW-1:0] br, bi, wr, wi, pr, pi;
  logic signed [DW-1:0] bwr, bwi;
  logic                 unused_bits;

  assign br = {{(PW-DW){b.re[DW-1]}}, b.re};
  assign bi = {{(PW-DW){b.im[DW-1]}}, b.im};
  assign wr = {{(PW-TW_W){w.re[TW_W-1]}}, w.re};
  assign wi = {{(PW-TW_W){w.im[TW_W-1]}}, w.im};

  assign pr = br * wr - bi * wi;
  assign pi = br * wi + bi * wr;

  // Selecting bits [TW_FRAC +: DW] is the floor shift followed by truncation.
  assign bwr = pr[TW_FRAC +: DW];
  assign bwi = pi[TW_FRAC +: DW];
  assign unused_bits = ^{pr[TW_FRAC-1:0], pr[PW-1:TW_FRAC+DW],
                         pi[TW_FRAC-1:0], pi[PW-1:TW_FRAC+DW]};

  assign ap.re = a.re + bwr;
  assign ap.im = a.im + bwi;
  assign bp.re = a.re - bwr;
  assign bp.im = a.im - bwi;
endmodule

// File: rtl/ifft8_unit.sv
// 8-point radix-2 DIT inverse FFT coprocessor, word-serial in and out.
// - clk, rst (async, active high), clr (sync abort back to LOAD)
// - bus  : ifft8_unit_if.slave, load (din*) and export (dout*) handshakes
// - busy : high in every state but LOAD
// Input words land at bit-reversed slots so the three in-place stages leave
// x[n] in slot n; four butterflies are shared across the stages.
module ifft8_unit
  import ifft8_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  ifft8_unit_if.slave  bus,
  output logic         busy
);
  state_t                      state;
  logic [3:0]                  cnt, idx, nidx;
  cplx_t [NPTS-1:0]            d;
  cplx_t [NUM_BF-1:0]          bfa, bfb, bfap, bfbp;
  tw_t   [NUM_BF-1:0]          bfw;
  logic  [NUM_BF-1:0][2:0]     ia, ib;
  logic  [DW-1:0]              nword;

  for (genvar l = 0; l < NUM_BF; l++) begin : g_bf
    assign ia[l]  = bf_a_idx(state, 2'(l));
    assign ib[l]  = bf_b_idx(state, 2'(l));
    assign bfa[l] = d[ia[l]];
    assign bfb[l] = d[ib[l]];
    assign bfw[l] = tw_conj(bf_tw_idx(state, 2'(l)));
    ifft_bf2 u_bf (.a(bfa[l]), .b(bfb[l]), .w(bfw[l]), .ap(bfap[l]), .bp(bfbp[l]));
  end

  assign nidx  = idx + 4'd1;
  assign nword = nidx[0] ? d[nidx[3:1]].im : d[nidx[3:1]].re;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_LOAD;
      cnt            <= '0;
      idx            <= '0;
      d              <= '0;
      bus.din_ready  <= 1'b1;
      bus.dout_valid <= 1'b0;
      bus.dout       <= '0;
      bus.dout_last  <= 1'b0;
      busy           <= 1'b0;
    end else if (clr) begin
      // Data registers are left alone; the next frame overwrites all of them.
      state          <= S_LOAD;
      cnt            <= '0;
      idx            <= '0;
      bus.din_ready  <= 1'b1;
      bus.dout_valid <= 1'b0;
      bus.dout_last  <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        S_LOAD: if (bus.din_valid) begin
          if (cnt[0]) d[rev3(cnt[3:1])].im <= bus.din;
          else        d[rev3(cnt[3:1])].re <= bus.din;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state         <= S_ST1;
            bus.din_ready <= 1'b0;
            busy          <= 1'b1;
          end
        end
        S_ST1, S_ST2: begin
          for (int l = 0; l < NUM_BF; l++) begin
            d[ia[l]] <= bfap[l];
            d[ib[l]] <= bfbp[l];
          end
          state <= (state == S_ST1) ? S_ST2 : S_ST3;
        end
        S_ST3: begin
          for (int l = 0; l < NUM_BF; l++) begin
            d[ia[l]] <= scale8(bfap[l]);
            d[ib[l]] <= scale8(bfbp[l]);
          end
          // Word 0 (x0.re) comes straight from lane 0 so it is ready on entry.
          bus.dout       <= $signed(bfap[0].re) >>> 3;
          bus.dout_valid <= 1'b1;
          bus.dout_last  <= 1'b0;
          idx            <= '0;
          state          <= S_EXPORT;
        end
        S_EXPORT: if (bus.dout_ready) begin
          if (idx == 4'd15) begin
            state          <= S_LOAD;
            idx            <= '0;
            bus.dout_valid <= 1'b0;
            bus.dout_last  <= 1'b0;
            bus.dout       <= '0;
            bus.din_ready  <= 1'b1;
            busy           <= 1'b0;
          end else begin
            idx           <= nidx;
            bus.dout      <= nword;
            bus.dout_last <= (idx == 4'd14);
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_ifft8_unit.sv
// Self-checking bench for ifft8_unit: bit-exact inverse DIT model, one
// compare process on every output handshake, plus literal expectations.
module tb_ifft8_unit;
  import ifft8_unit_pkg::*;

  typedef int arr8_t[8];
  typedef int arr16_t[16];

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic busy;

  ifft8_unit_if bus();
  ifft8_unit dut (.clk(clk), .rst(rst), .clr(clr), .bus(bus), .busy(busy));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = -100;
  int cap_cnt = 0;
  int cap[16];
  int exp_q[$];

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void chk_tol(string name, longint act, longint exp, longint tol);
    longint diff;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    checks++;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (+/-%0d)", name, act, exp, tol);
    end
  endfunction

  function automatic void timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endfunction

  // x[n] = (1/8) sum X[k] W^-nk, evaluated as the radix-2 recursion with the
  // same fixed-point rules: floor(product >> 14), 32-bit wrap, final floor /8.
  function automatic void model(input arr8_t xr, input arr8_t xi, output arr16_t y);
    int re[8], im[8];
    int tr[4], ti[4];
    int r, t, ia, ib, bwr, bwi, ar, ai;
    longint pr, pi;
    tr = '{16384, 11585, 0, -11585};
    ti = '{0, 11585, 16384, 11585};
    for (int k = 0; k < 8; k++) begin
      r = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
      re[r] = xr[k];
      im[r] = xi[k];
    end
    for (int span = 1; span < 8; span *= 2)
      for (int base = 0; base < 8; base += 2 * span)
        for (int j = 0; j < span; j++) begin
          t  = j * (4 / span);
          ia = base + j;
          ib = ia + span;
          pr = longint'(re[ib]) * tr[t] - longint'(im[ib]) * ti[t];
          pi = longint'(re[ib]) * ti[t] + longint'(im[ib]) * tr[t];
          bwr = int'(pr >>> 14);
          bwi = int'(pi >>> 14);
          ar = re[ia];
          ai = im[ia];
          re[ia] = ar + bwr;  im[ia] = ai + bwi;
          re[ib] = ar - bwr;  im[ib] = ai - bwi;
        end
    for (int n = 0; n < 8; n++) begin
      y[2*n]   = re[n] >>> 3;
      y[2*n+1] = im[n] >>> 3;
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: every accepted output word against the model queue.
  always @(negedge clk) begin
    if (!rst && !clr && bus.din_valid && bus.din_ready) last_acc = cyc;
    if (!rst && bus.dout_valid && bus.dout_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dout_extra: got %0d expected no word", $signed(bus.dout));
      end else begin
        chk("dout", $signed(bus.dout), exp_q.pop_front());
        chk("dout_last", bus.dout_last, cap_cnt == 15);
        if (cap_cnt < 16) cap[cap_cnt] = $signed(bus.dout);
        cap_cnt++;
      end
    end
  end

  task automatic send_words(input arr16_t w, input int n, input bit gaps);
    bit acc;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        bus.din_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      bus.din_valid = 1'b1;
      bus.din       = w[i];
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) begin
        @(negedge clk);
        acc = bus.din_ready;
        @(posedge clk);
        #1;
      end
      if (!acc) timeout("din_accept");
    end
    bus.din_valid = 1'b0;
  endtask

  task automatic run_frame(input arr8_t xr, input arr8_t xi, input bit gaps,
                           input int stall_at, input int rst_at);
    arr16_t w, y;
    bit seen, stalled;
    model(xr, xi, y);
    for (int i = 0; i < 16; i++) exp_q.push_back(y[i]);
    for (int k = 0; k < 8; k++) begin
      w[2*k]   = xr[k];
      w[2*k+1] = xi[k];
    end
    cap_cnt = 0;
    send_words(w, 16, gaps);
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (bus.dout_valid) seen = 1'b1;
    end
    if (!seen) timeout("first_dout_valid");
    else begin
      chk("latency", cyc - last_acc, 4);
      chk("busy_export", busy, 1);
      chk("din_ready_export", bus.din_ready, 0);
    end
    @(posedge clk);
    #1;
    stalled = 1'b0;
    for (int t = 0; t < 300 && cap_cnt < 16; t++) begin
      if (rst_at >= 0 && bus.dout_valid && cap_cnt == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_dout_valid", bus.dout_valid, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_dout_last", bus.dout_last, 0);
        chk("rst_din_ready", bus.din_ready, 1);
        chk("rst_busy", busy, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      if (stall_at >= 0 && !stalled && bus.dout_valid && cap_cnt == stall_at) begin
        bus.dout_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_dout", $signed(bus.dout), y[stall_at]);
          chk("stall_last", bus.dout_last, stall_at == 15);
          chk("stall_valid", bus.dout_valid, 1);
        end
        @(posedge clk);
        #1;
        bus.dout_ready = 1'b1;
        stalled = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (cap_cnt < 16) timeout("export_drain");
    chk("words_out", cap_cnt, 16);
    chk("exp_left", exp_q.size(), 0);
    chk("end_din_ready", bus.din_ready, 1);
    chk("end_busy", busy, 0);
    chk("end_dout_valid", bus.dout_valid, 0);
  endtask

  task automatic check_t1(input string tag);
    for (int n = 0; n < 8; n++) begin
      chk({tag, "_re"}, cap[2*n], 100);
      chk({tag, "_im"}, cap[2*n+1], 0);
    end
  endtask

  task automatic check_t2(input string tag);
    chk({tag, "_x0re"}, cap[0], 8);
    for (int i = 1; i < 16; i++) chk({tag, "_zero"}, cap[i], 0);
  endtask

  task automatic check_t3(input string tag, input arr16_t v);
    chk({tag, "_x0re"}, v[0], 100);   chk({tag, "_x0im"}, v[1], 0);
    chk({tag, "_x2re"}, v[4], 0);     chk({tag, "_x2im"}, v[5], 100);
    chk({tag, "_x4re"}, v[8], -100);  chk({tag, "_x4im"}, v[9], 0);
    chk({tag, "_x6re"}, v[12], 0);    chk({tag, "_x6im"}, v[13], -100);
    chk_tol({tag, "_x1re"}, v[2], 70, 1);   chk_tol({tag, "_x1im"}, v[3], 70, 1);
    chk_tol({tag, "_x3re"}, v[6], -71, 1);  chk_tol({tag, "_x3im"}, v[7], 70, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    arr8_t z, t1r, t2r, t3r, t4r, t4i;
    arr16_t y, c16;
    z   = '{0, 0, 0, 0, 0, 0, 0, 0};
    t1r = '{800, 0, 0, 0, 0, 0, 0, 0};
    t2r = '{8, 8, 8, 8, 8, 8, 8, 8};
    t3r = '{0, 800, 0, 0, 0, 0, 0, 0};
    t4r = '{1000, -2000, 3000, 0, -500, 700, 123, -4567};
    t4i = '{0, 250, -750, 999, 1, -1, 40000, -8};
    bus.din_valid  = 1'b0;
    bus.din        = '0;
    bus.dout_ready = 1'b1;

    // Pin the model itself against hand-computed results.
    model(t1r, z, y);
    chk("model_t1_x5re", y[10], 100);
    chk("model_t1_x7im", y[15], 0);
    model(t2r, z, y);
    chk("model_t2_x0re", y[0], 8);
    chk("model_t2_x3re", y[6], 0);
    model(t3r, z, y);
    check_t3("model_t3", y);
    chk("model_t3_x5re", y[10], -71);
    chk("model_t3_x7im", y[15], -71);

    #2 rst = 1'b1;
    #1;
    chk("reset_din_ready", bus.din_ready, 1);
    chk("reset_dout_valid", bus.dout_valid, 0);
    chk("reset_dout", bus.dout, 0);
    chk("reset_dout_last", bus.dout_last, 0);
    chk("reset_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: DC bin only.
    run_frame(t1r, z, 1'b0, -1, -1);
    check_t1("t1");
    // Test 2: flat spectrum -> impulse.
    run_frame(t2r, z, 1'b0, -1, -1);
    check_t2("t2");
    // Test 3: single bin 1 -> rotating phasor.
    run_frame(t3r, z, 1'b0, -1, -1);
    for (int i = 0; i < 16; i++) c16[i] = cap[i];
    check_t3("t3", c16);
    // Test 4: back-pressure while word 3 is presented.
    run_frame(t4r, t4i, 1'b0, 3, -1);
    // Test 5: random input gaps with the Test 1 data.
    run_frame(t1r, z, 1'b1, -1, -1);
    check_t1("t5");
    // Test 6: reset during export word 7, then a clean Test 2 frame.
    run_frame(t4r, t4i, 1'b0, -1, 7);
    run_frame(t2r, z, 1'b0, -1, -1);
    check_t2("t6_rst");

    // Test 6 (clr): abort at load word 9, then a full frame.
    for (int k = 0; k < 8; k++) begin
      c16[2*k]   = t4r[k];
      c16[2*k+1] = t4i[k];
    end
    send_words(c16, 9, 1'b0);
    clr = 1'b1;
    bus.din_valid = 1'b1;
    bus.din = 32'd12345;
    @(posedge clk);
    #1;
    clr = 1'b0;
    bus.din_valid = 1'b0;
    chk("clr_din_ready", bus.din_ready, 1);
    chk("clr_busy", busy, 0);
    chk("clr_dout_valid", bus.dout_valid, 0);
    run_frame(t3r, z, 1'b0, -1, -1);
    for (int i = 0; i < 16; i++) c16[i] = cap[i];
    check_t3("t6_clr", c16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
